xy_fill_writer: RTL and testbench
=================================

XY_FILL_WRITER -- requirements
Module: xy_fill_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 96: display width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 64: display height in pixels.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1: a fill request is presented.
REQ-006 SHALL have port req_ready, output, 1: the block can accept a request.
REQ-007 SHALL have ports x0, x1, input, 8 each: rectangle corner X coordinates.
REQ-008 SHALL have ports y0, y1, input, 8 each: rectangle corner Y coordinates.
REQ-009 SHALL have port color, input, 16: RGB565 fill value.
REQ-010 SHALL have port wr_en, output, 1: framebuffer write strobe.
REQ-011 SHALL have port wr_addr, output, 13: pixel index, equal to y*WIDTH+x.
REQ-012 SHALL have port wr_data, output, 16: write data.
REQ-013 SHALL have ports busy and done, output, 1 each: busy is high outside IDLE; done is a 1-cycle completion pulse.
REQ-014 SHALL have port err, output, 1: pulses together with done when a request is rejected.

Function
REQ-015 SHALL implement states IDLE, FILL and DONE; req_ready SHALL be 1 only in IDLE.
REQ-016 SHALL accept a request on a cycle with req_valid=1 and req_ready=1, and SHALL latch the corners and color on that cycle.
REQ-017 SHALL normalize the corners at accept time: xl=min(x0,x1), xh=max(x0,x1), yl=min(y0,y1), yh=max(y0,y1).
REQ-018 SHALL move from IDLE to FILL after accepting a valid request; the first wr_en SHALL occur the cycle after accept.
REQ-019 SHALL issue exactly one write per cycle in FILL, in raster order: x from xl to xh, then y+1, with x wrapping back to xl.
REQ-020 SHALL compute wr_addr incrementally, without a multiplier: the row base starts at yl*WIDTH (shift-add) and adds WIDTH per row; wr_addr = row base + x.
REQ-021 SHALL register wr_en, wr_addr and wr_data; wr_data SHALL equal the latched color.
REQ-022 SHALL move to DONE after the write of (xh,yh), pulse done for one cycle in DONE, and return to IDLE on the next cycle.
REQ-023 SHALL issue (xh-xl+1)*(yh-yl+1) writes per accepted request; a 1x1 rectangle SHALL produce one write.
REQ-024 SHALL ignore req_valid and all request inputs while busy=1.
REQ-025 SHALL hold wr_en=0 in IDLE and DONE.

Reset
REQ-026 SHALL, when rst_n=0 at a clock edge, enter IDLE and force req_ready=1, busy=0, done=0, err=0, wr_en=0, wr_addr=0 and wr_data=0.
REQ-027 SHALL abort a fill in progress on reset: no write SHALL occur on the cycle after reset is sampled low, and the aborted request SHALL NOT produce a done pulse.

Configuration
REQ-028 SHALL compile clipping in when macro XY_FILL_CLIP_EN is defined: at accept, xh is clamped to WIDTH-1 and yh to HEIGHT-1, and a request with xl>=WIDTH or yl>=HEIGHT is rejected.
REQ-029 SHALL, without XY_FILL_CLIP_EN, reject any request with xh>=WIDTH or yh>=HEIGHT.
REQ-030 SHALL handle a rejected request as follows: go IDLE->DONE with zero writes, then pulse done and err together for one cycle.

Verification
REQ-031 Single pixel: x0=x1=5, y0=y1=3 -> one write, wr_addr=293, done pulse the cycle after the write, err=0.
REQ-032 Full screen: (0,0)-(95,63), color=16'hF800 -> 6144 writes with wr_addr 0..6143 on consecutive cycles, then done.
REQ-033 Swapped corners: (10,2)-(8,1) -> wr_addr sequence 104, 105, 106, 200, 201, 202, then done.
REQ-034 Out of range: (90,60)-(100,70) -> with XY_FILL_CLIP_EN: 24 writes, first 5850, last 6143; without it: zero writes, done=err=1 for one cycle.
REQ-035 Reset mid-fill: assert rst_n=0 during the 3rd write of (0,0)-(95,0) -> wr_en=0 from the next cycle, no done pulse, req_ready=1 after reset is released.
REQ-036 Back-to-back: req_valid held high with a second request -> the second request is accepted only in the IDLE cycle after done, and its writes follow with no overlap with the first request.

Source files
------------

// File: rtl/xy_fill_writer.sv
// Rectangle fill engine: streams one framebuffer write per cycle in raster order.
// Optional clipping is compiled in with macro XY_FILL_CLIP_EN.
module xy_fill_writer #(
   parameter int WIDTH  = 96,
   parameter int HEIGHT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [7:0]  x0,
   input  logic [7:0]  x1,
   input  logic [7:0]  y0,
   input  logic [7:0]  y1,
   input  logic [15:0] color,
   output logic        wr_en,
   output logic [12:0] wr_addr,
   output logic [15:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic        err
);

   // state | meaning
   // IDLE  | waiting for a request, req_ready high
   // FILL  | one write presented on wr_* every cycle
   // DONE  | done pulse (with err if the request was rejected)
   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   localparam logic [7:0]  X_MAX = 8'(WIDTH - 1);
   localparam logic [7:0]  Y_MAX = 8'(HEIGHT - 1);
   localparam logic [12:0] W13   = 13'(WIDTH);

   state_t      state, state_nx;
   logic [7:0]  n_xl, n_xh, n_yl, n_yh;
   logic [7:0]  xl, xh, yh, cx, cy;
   logic [12:0] row_base, row0;
   logic        reject, accept, last, err_q;

   // Constant-coefficient multiply by WIDTH as a sum of shifted terms.
   function automatic logic [12:0] mul_width(input logic [7:0] y);
      logic [12:0] acc;
      acc = '0;
      for (int i = 0; i < 13; i++)
         if (W13[i]) acc = acc + (13'(y) << i);
      return acc;
   endfunction

   always_comb begin
      n_xl = (x0 < x1) ? x0 : x1;
      n_xh = (x0 < x1) ? x1 : x0;
      n_yl = (y0 < y1) ? y0 : y1;
      n_yh = (y0 < y1) ? y1 : y0;
`ifdef XY_FILL_CLIP_EN
      reject = (n_xl > X_MAX) || (n_yl > Y_MAX);
      if (n_xh > X_MAX) n_xh = X_MAX;
      if (n_yh > Y_MAX) n_yh = Y_MAX;
`else
      reject = (n_xh > X_MAX) || (n_yh > Y_MAX);
`endif
   end

   assign row0      = mul_width(n_yl);
   assign accept    = req_valid && (state == IDLE);
   assign last      = (cx == xh) && (cy == yh);
   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign err       = done && err_q;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = reject ? DONE : FILL;
         FILL:    if (last) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // The first pixel is registered on the accept edge so it appears the next cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         err_q    <= 1'b0;
         xl       <= '0;
         xh       <= '0;
         yh       <= '0;
         cx       <= '0;
         cy       <= '0;
         row_base <= '0;
      end else begin
         case (state)
            IDLE: begin
               wr_en <= 1'b0;
               if (accept) begin
                  err_q    <= reject;
                  xl       <= n_xl;
                  xh       <= n_xh;
                  yh       <= n_yh;
                  cx       <= n_xl;
                  cy       <= n_yl;
                  row_base <= row0;
                  wr_data  <= color;
                  if (!reject) begin
                     wr_en   <= 1'b1;
                     wr_addr <= row0 + {5'b0, n_xl};
                  end
               end
            end
            FILL: begin
               if (last) begin
                  wr_en <= 1'b0;
               end else if (cx == xh) begin
                  cx       <= xl;
                  cy       <= cy + 8'd1;
                  row_base <= row_base + W13;
                  wr_addr  <= row_base + W13 + {5'b0, xl};
               end else begin
                  cx      <= cx + 8'd1;
                  wr_addr <= wr_addr + 13'd1;
               end
            end
            default: wr_en <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_xy_fill_writer.sv
// Bench for xy_fill_writer: vector table plus reset-abort and back-to-back sequences.
// Expected writes come from a raster model pushed to a scoreboard queue.
module tb_xy_fill_writer;

   localparam int W = 96;
   localparam int H = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [7:0]  x0 = '0, x1 = '0, y0 = '0, y1 = '0;
   logic [15:0] color = '0;
   logic        req_ready, wr_en, busy, done, err;
   logic [12:0] wr_addr;
   logic [15:0] wr_data;

   xy_fill_writer #(.WIDTH(W), .HEIGHT(H)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [12:0] addr;
      logic [15:0] data;
   } exp_wr_t;

   typedef struct {
      logic [7:0]  x0, x1, y0, y1;
      logic [15:0] color;
      int          n;
      bit          err;
      int          first;
      int          last;
   } vec_t;

   exp_wr_t     sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          n_wr = 0;
   int          first_cyc = 0;
   int          last_cyc = 0;
   int          done_cnt = 0;
   logic [12:0] first_addr = '0;
   logic [12:0] last_addr = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && wr_en) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual addr=%0d required no write", wr_addr);
         end else begin
            exp_wr_t e;
            e = sb.pop_front();
            chk("wr_addr", 32'(wr_addr), 32'(e.addr));
            chk("wr_data", 32'(wr_data), 32'(e.data));
         end
         if (n_wr == 0) begin
            first_cyc  = cyc;
            first_addr = wr_addr;
         end
         last_cyc  = cyc;
         last_addr = wr_addr;
         n_wr++;
      end
      if (rst_n && done) done_cnt++;
   end

   task automatic push_model(input logic [7:0] a0, a1, b0, b1, input logic [15:0] c);
      int xl, xh, yl, yh;
      bit rej;
      xl = (a0 < a1) ? a0 : a1;
      xh = (a0 < a1) ? a1 : a0;
      yl = (b0 < b1) ? b0 : b1;
      yh = (b0 < b1) ? b1 : b0;
`ifdef XY_FILL_CLIP_EN
      rej = (xl >= W) || (yl >= H);
      if (xh > W - 1) xh = W - 1;
      if (yh > H - 1) yh = H - 1;
`else
      rej = (xh >= W) || (yh >= H);
`endif
      if (!rej)
         for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++) begin
               exp_wr_t e;
               e.addr = 13'(y * W + x);
               e.data = c;
               sb.push_back(e);
            end
   endtask

   task automatic wait_ready(input string name);
      int k;
      for (k = 0; k < 10000 && !req_ready; k++) @(negedge clk);
      if (!req_ready) chk({name, "_ready_timeout"}, 32'(req_ready), 32'd1);
   endtask

   task automatic wait_done(input string name, output int at);
      int k;
      at = -1;
      for (k = 0; k < 8000; k++) begin
         @(negedge clk);
         if (done) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) chk({name, "_done_timeout"}, 32'(done), 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int acc, done_at;
      string nm;
      nm = $sformatf("vec%0d", idx);
      n_wr = 0;
      @(negedge clk);
      x0 = v.x0; x1 = v.x1; y0 = v.y0; y1 = v.y1; color = v.color;
      req_valid = 1'b1;
      push_model(v.x0, v.x1, v.y0, v.y1, v.color);
      wait_ready(nm);
      acc = cyc + 1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      x0 = 8'($urandom); x1 = 8'($urandom); y0 = 8'($urandom); y1 = 8'($urandom);
      color = 16'($urandom);
      wait_done(nm, done_at);
      chk({nm, "_nwrites"}, 32'(n_wr), 32'(v.n));
      chk({nm, "_err"}, 32'(err), 32'(v.err));
      chk({nm, "_sb_left"}, 32'(sb.size()), 32'd0);
      if (v.n > 0) begin
         chk({nm, "_first_addr"}, 32'(first_addr), 32'(v.first));
         chk({nm, "_last_addr"}, 32'(last_addr), 32'(v.last));
         chk({nm, "_first_latency"}, 32'(first_cyc), 32'(acc));
         chk({nm, "_span"}, 32'(last_cyc - first_cyc + 1), 32'(v.n));
         chk({nm, "_done_after_last"}, 32'(done_at), 32'(last_cyc + 1));
      end else begin
         chk({nm, "_reject_done_cycle"}, 32'(done_at), 32'(acc));
      end
      @(negedge clk);
      chk({nm, "_done_pulse_end"}, 32'(done), 32'd0);
      chk({nm, "_ready_after"}, 32'(req_ready), 32'd1);
      sb.delete();
   endtask

   vec_t vecs[8];

   initial begin
      int done_a, done_b, acc_b, base_done;
      bit seen_a;

      vecs[0] = '{8'd5, 8'd5, 8'd3, 8'd3, 16'h1234, 1, 1'b0, 293, 293};
      vecs[1] = '{8'd0, 8'd95, 8'd0, 8'd63, 16'hF800, 6144, 1'b0, 0, 6143};
      vecs[2] = '{8'd10, 8'd8, 8'd2, 8'd1, 16'h07E0, 6, 1'b0, 104, 202};
`ifdef XY_FILL_CLIP_EN
      vecs[3] = '{8'd90, 8'd100, 8'd60, 8'd70, 16'h001F, 24, 1'b0, 5850, 6143};
      vecs[7] = '{8'd200, 8'd0, 8'd5, 8'd5, 16'h5555, 96, 1'b0, 480, 575};
`else
      vecs[3] = '{8'd90, 8'd100, 8'd60, 8'd70, 16'h001F, 0, 1'b1, 0, 0};
      vecs[7] = '{8'd200, 8'd0, 8'd5, 8'd5, 16'h5555, 0, 1'b1, 0, 0};
`endif
      vecs[4] = '{8'd3, 8'd7, 8'd12, 8'd10, 16'hABCD, 15, 1'b0, 963, 1159};
      vecs[5] = '{8'd95, 8'd95, 8'd63, 8'd63, 16'h0001, 1, 1'b0, 6143, 6143};
      vecs[6] = '{8'd0, 8'd1, 8'd64, 8'd64, 16'h2222, 0, 1'b1, 0, 0};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Reset during the third write of a one-row fill
      n_wr = 0;
      @(negedge clk);
      x0 = 8'd0; x1 = 8'd95; y0 = 8'd0; y1 = 8'd0; color = 16'h0F0F;
      req_valid = 1'b1;
      push_model(8'd0, 8'd95, 8'd0, 8'd0, 16'h0F0F);
      wait_ready("rst_mid");
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_mid_writes_before", 32'(n_wr), 32'd3);
      base_done = done_cnt;
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_wr_en", 32'(wr_en), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      #1 rst_n = 1'b1;
      sb.delete();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("rst_mid_no_wr", 32'(wr_en), 32'd0);
      end
      chk("rst_mid_no_done", 32'(done_cnt), 32'(base_done));
      chk("rst_mid_ready", 32'(req_ready), 32'd1);

      // Back-to-back: valid held high, second request must wait for IDLE after done
      n_wr = 0;
      seen_a = 1'b0;
      done_a = -1;
      acc_b = -1;
      @(negedge clk);
      x0 = 8'd1; x1 = 8'd3; y0 = 8'd0; y1 = 8'd0; color = 16'hAAAA;
      req_valid = 1'b1;
      push_model(8'd1, 8'd3, 8'd0, 8'd0, 16'hAAAA);
      wait_ready("b2b_a");
      @(posedge clk);
      #1;
      x0 = 8'd7; x1 = 8'd8; y0 = 8'd2; y1 = 8'd2; color = 16'hBBBB;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (done && !seen_a) begin
            seen_a = 1'b1;
            done_a = cyc;
         end else if (req_ready) begin
            acc_b = cyc;
            break;
         end
      end
      chk("b2b_first_done_seen", 32'(seen_a), 32'd1);
      chk("b2b_accept_cycle", 32'(acc_b), 32'(done_a + 1));
      push_model(8'd7, 8'd8, 8'd2, 8'd2, 16'hBBBB);
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_done("b2b_b", done_b);
      chk("b2b_nwrites", 32'(n_wr), 32'd5);
      chk("b2b_sb_left", 32'(sb.size()), 32'd0);
      chk("b2b_err", 32'(err), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
